// File: rtl/div_32u.sv
// -----------------------------------------------------------------------------
// div_32u
//   Iterative unsigned divider (restoring, one quotient bit per clock) for the
//   DIVU/REMU path of the execute stage. A start pulse loads the operands, the
//   compare-and-subtract loop runs for WIDTH cycles, and a one-cycle done pulse
//   presents quotient and remainder. Divide-by-zero completes immediately with
//   the RISC-V results (quotient all ones, remainder = dividend).
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset, highest priority
//   start_i        request a division; ignored while busy_o is high
//   dividend_i     unsigned dividend, sampled with start_i
//   divisor_i      unsigned divisor, sampled with start_i
//   busy_o         iteration loop in progress
//   done_o         one-cycle pulse, results valid in this cycle
//   quotient_o     quotient of the last completed operation
//   remainder_o    remainder of the last completed operation
//   div_by_zero_o  last completed operation had divisor 0
// -----------------------------------------------------------------------------
module div_32u #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] d;      // latched divisor
    logic [WIDTH-1:0] q;      // quotient shift register, dividend bits shift out the top
    // The partial remainder is always < D after a step, so its top bit is
    // permanently zero and only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   t;      // shifted trial remainder, WIDTH+1 bits
    logic             ge;     // trial remainder covers the divisor
    logic [WIDTH-1:0] diff;   // T - D; exact whenever ge is set since T - D < D

    always_comb begin
        t    = {r, q[WIDTH-1]};
        ge   = (t >= {1'b0, d});
        diff = t[WIDTH-1:0] - d;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            d             <= '0;
            q             <= '0;
            r             <= '0;
            cnt           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        cnt <= '0;
                        if (divisor_i == '0) begin
                            // No iterations: results are fixed by the ISA.
                            q             <= '1;
                            r             <= dividend_i;
                            div_by_zero_o <= 1'b1;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            d             <= divisor_i;
                            q             <= dividend_i;
                            r             <= '0;
                            div_by_zero_o <= 1'b0;
                            busy_o        <= 1'b1;
                            state         <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    r   <= ge ? diff : t[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign quotient_o  = q;
    assign remainder_o = r;

endmodule

// File: tb/tb_div_32u.sv
// -----------------------------------------------------------------------------
// tb_div_32u
//   Scoreboard bench for div_32u. Each accepted start pushes the expected
//   result (plain / and %) and its completion cycle into a queue; a monitor on
//   the falling edge checks busy_o, done_o and the result/hold values.
// -----------------------------------------------------------------------------
module tb_div_32u;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    div_32u #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int           cyc;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Called just after a rising edge; start_i is sampled at the next edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   c;
        c          = cyc;
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        if (!(c >= busy_lo && c <= busy_hi)) begin
            accepted++;
            if (b == 0) begin
                e.cyc = c + 1;
                e.q   = '1;
                e.r   = a;
                e.dbz = 1'b1;
            end else begin
                busy_lo = c + 1;
                busy_hi = c + W;
                e.cyc   = c + W + 1;
                e.q     = a / b;
                e.r     = a % b;
                e.dbz   = 1'b0;
            end
            exp_q.push_back(e);
        end
        step(1);
        start_i = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        step(n);
        rst_i   = 1'b0;
        exp_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        held    = '{cyc: 0, q: '0, r: '0, dbz: 1'b0};
        mon_en  = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step(1);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            bit   exp_done;
            bit   in_run;
            exp_t e;
            exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            in_run   = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("busy", busy_o, in_run);
            check("done", done_o, exp_done);
            if (exp_done) begin
                e = exp_q.pop_front();
                check("quotient", quotient_o, e.q);
                check("remainder", remainder_o, e.r);
                check("div_by_zero", div_by_zero_o, e.dbz);
                held = e;
            end else if (!in_run) begin
                check("hold_quotient", quotient_o, held.q);
                check("hold_remainder", remainder_o, held.r);
                check("hold_div_by_zero", div_by_zero_o, held.dbz);
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        step(1);
        do_reset(3);
        step(2);

        // Basic cases, including divisor 1 and dividend < divisor.
        issue(32'd100, 32'd7);
        drain();
        step(2);
        issue(32'hFFFF_FFFF, 32'd1);
        drain();
        issue(32'd3, 32'd10);
        drain();
        step(1);

        // Divide by zero completes in the cycle after the start.
        issue(32'd5, 32'd0);
        drain();
        step(3);

        // Start during RUN is ignored (model rejects it as well).
        issue(32'd1000, 32'd3);
        step(9);
        issue(32'd9, 32'd2);
        drain();
        step(2);

        // Back-to-back: second start lands exactly in the done cycle.
        issue(32'd1000, 32'd3);
        step(W);
        issue(32'hDEAD_BEEF, 32'h10);
        drain();
        step(2);

        // Divide by zero followed immediately by a normal start in its done cycle.
        issue(32'd77, 32'd0);
        issue(32'd77, 32'd8);
        drain();

        // Reset mid-RUN aborts the operation; no done pulse follows.
        issue(32'd50, 32'd5);
        step(9);
        do_reset(1);
        step(40);
        issue(32'd50, 32'd5);
        drain();

        // Randomized traffic with random gaps; starts during RUN are dropped.
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 40));
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = a >> $urandom_range(0, 31);
                3: b = '1;
                default: b = $urandom;
            endcase
            if (b == 0 && ($urandom_range(0, 1) == 1)) b = 32'd1;
            issue(a, b);
        end
        drain();
        step(3);

        if (accepted < 20) check("accepted_count", accepted, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
